transmissor_codigo: RTL and testbench

- Sequencer that drives the digit-entry interface of the code-lock machine (numero[4:1] / insere) and reads back its LED.
- Stores a code of N_DIGITOS digits written over a small register port.
- On a start command it presents the digits one by one with fixed pacing, then waits a bounded time for LED.
- Reports accept or reject; used as the on-chip stimulus and self-test source for the lock.

---
 rtl/transmissor_codigo.sv | 164 ++++++++++++++++
 tb/tb_transmissor_codigo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_codigo.sv
// transmissor_codigo: paced digit sequencer and result reader for the code lock. Rev 1.0
// Optional macro REPETE_EN: one retransmission after an ESPERA timeout, adds tentativas output.
`default_nettype none

module transmissor_codigo #(
  parameter int N_DIGITOS = 4,
  parameter int T_INSERE  = 1,
  parameter int T_PAUSA   = 2,
  parameter int T_ESPERA  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       grava,
  input  logic [2:0] endereco,
  input  logic [3:0] dado,
  input  logic       iniciar,
  input  logic       LED,
  output logic [4:1] numero,
  output logic       insere,
  output logic       ocupado,
  output logic       concluido,
`ifdef REPETE_EN
  output logic [1:0] tentativas,
`endif
  output logic       aceito
);

  localparam int T_MAX = (T_INSERE > T_PAUSA) ?
                         ((T_INSERE > T_ESPERA) ? T_INSERE : T_ESPERA) :
                         ((T_PAUSA  > T_ESPERA) ? T_PAUSA  : T_ESPERA);
  localparam int CW = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LAST_INS = CW'(T_INSERE - 1);
  localparam logic [CW-1:0] LAST_PAU = CW'(T_PAUSA - 1);
  localparam logic [CW-1:0] LAST_ESP = CW'(T_ESPERA - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(T_MAX);
  localparam logic [2:0]    LAST_IDX = 3'(N_DIGITOS - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ENVIA   = 3'd1,
    PAUSA   = 3'd2,
    ESPERA  = 3'd3,
    FIM     = 3'd4,
    RETENTA = 3'd5
  } estado_t;

  estado_t       estado, proximo;
  logic [CW-1:0] cnt;
  logic [2:0]    indice;
  logic [3:0]    slot [8];
  logic          inicia, avanca, acerto;
`ifdef REPETE_EN
  logic          repete;
`endif

  always_comb begin
    proximo   = estado;
    inicia    = 1'b0;
    avanca    = 1'b0;
    acerto    = 1'b0;
`ifdef REPETE_EN
    repete    = 1'b0;
`endif
    numero    = 4'd0;
    insere    = 1'b0;
    ocupado   = 1'b0;
    concluido = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          proximo = ENVIA;
          inicia  = 1'b1;
        end
      end
      ENVIA: begin
        numero  = slot[indice];
        insere  = 1'b1;
        ocupado = 1'b1;
        if (cnt == LAST_INS) proximo = PAUSA;
      end
      PAUSA: begin
        numero  = slot[indice];
        ocupado = 1'b1;
        if (cnt == LAST_PAU) begin
          if (indice == LAST_IDX) begin
            proximo = ESPERA;
          end else begin
            proximo = ENVIA;
            avanca  = 1'b1;
          end
        end
      end
      ESPERA: begin
        ocupado = 1'b1;
        // LED wins over a timeout landing on the same edge
        if (LED) begin
          proximo = FIM;
          acerto  = 1'b1;
        end else if (cnt == LAST_ESP) begin
`ifdef REPETE_EN
          if (tentativas == 2'd1) begin
            proximo = RETENTA;
            repete  = 1'b1;
          end else begin
            proximo = FIM;
          end
`else
          proximo = FIM;
`endif
        end
      end
      RETENTA: begin
        ocupado = 1'b1;
        if (cnt == LAST_PAU) proximo = ENVIA;
      end
      FIM: begin
        concluido = 1'b1;
        proximo   = OCIOSO;
      end
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      cnt    <= '0;
      indice <= 3'd0;
      aceito <= 1'b0;
`ifdef REPETE_EN
      tentativas <= 2'd0;
`endif
      for (int i = 0; i < 8; i++) slot[i] <= 4'd0;
    end else begin
      estado <= proximo;
      if (proximo != estado) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + CW'(1);

      if (inicia) begin
        indice <= 3'd0;
        aceito <= 1'b0;
      end
`ifdef REPETE_EN
      else if (repete) indice <= 3'd0;
`endif
      else if (avanca) indice <= indice + 3'd1;

      if (acerto) aceito <= 1'b1;

`ifdef REPETE_EN
      if (inicia) tentativas <= 2'd1;
      else if (repete) tentativas <= 2'd2;
`endif

      // the code is frozen from the accepted start until FIM
      if (grava && !ocupado && !inicia && ({1'b0, endereco} < 4'(N_DIGITOS)))
        slot[endereco] <= dado;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_transmissor_codigo.sv
// Self-checking bench for transmissor_codigo against a timeline model of the transaction.
`default_nettype none

module tb_transmissor_codigo;

  localparam int N  = 4;
  localparam int TI = 1;
  localparam int TP = 2;
  localparam int TE = 8;
  localparam int P  = TI + TP;
  localparam int D  = N * P;
  localparam int A  = D + TE;
  localparam int O  = A + TP;
`ifdef REPETE_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, grava, iniciar, LED;
  logic [2:0] endereco;
  logic [3:0] dado;
  logic [4:1] numero;
  logic       insere, ocupado, concluido, aceito;
`ifdef REPETE_EN
  logic [1:0] tentativas;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int model [N];

  always #5 clk = ~clk;

  transmissor_codigo #(
    .N_DIGITOS(N), .T_INSERE(TI), .T_PAUSA(TP), .T_ESPERA(TE)
  ) dut (
    .clk(clk), .reset(reset), .grava(grava), .endereco(endereco), .dado(dado),
    .iniciar(iniciar), .LED(LED), .numero(numero), .insere(insere),
    .ocupado(ocupado), .concluido(concluido),
`ifdef REPETE_EN
    .tentativas(tentativas),
`endif
    .aceito(aceito)
  );

  // LED pulsed in cycle 'led' is accepted only inside an ESPERA window
  function automatic logic acc_of(input int led);
    if (led >= D + 1 && led <= A) return 1'b1;
    if (RETRY == 1 && led >= O + D + 1 && led <= O + A) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int end_of(input int led);
    if (acc_of(led)) return led + 1;
    return (RETRY == 1) ? O + A + 1 : A + 1;
  endfunction

  // position inside the current attempt (1..A), 0 when idle
  function automatic int pos(input int t, input int endc);
    if (t < 1 || t >= endc) return 0;
    if (t <= A) return t;
    if (RETRY == 1 && t > O) return t - O;
    return 0;
  endfunction

  function automatic logic exp_ins(input int p);
    return (p >= 1) && (p <= D) && (((p - 1) % P) < TI);
  endfunction

  function automatic logic [3:0] exp_num(input int p);
    if (p >= 1 && p <= D) return 4'(model[(p - 1) / P]);
    return 4'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int a, input int v);
    grava = 1'b1; endereco = 3'(a); dado = 4'(v);
    tick();
    grava = 1'b0;
    if (a < N) model[a] = v;
  endtask

  task automatic test_reset;
    logic [7:0] act;
    #2;
    act = {insere, numero, ocupado, concluido, aceito};
    n_checks++;
    if (act !== 8'h00) $display("FAIL reset_outputs got %b want 00000000", act);
    else n_pass++;
    @(negedge clk);
    #1 reset = 1'b0;
    tick();
    @(negedge clk);
    act = {insere, numero, ocupado, concluido, aceito};
    n_checks++;
    if (act !== 8'h00) $display("FAIL reset_idle got %b want 00000000", act);
    else n_pass++;
    tick();
  endtask

  // reject, accept two cycles into ESPERA, early LED during digit 1
  task automatic test_led_handling;
    int leds [3];
    int endc, p, led;
    logic acc;
    logic [7:0] act, exp;
    leds[0] = 0; leds[1] = D + 2; leds[2] = 1 + P;
    write_slot(0, 5); write_slot(1, 9); write_slot(2, 0); write_slot(3, 9);
    for (int k = 0; k < 3; k++) begin
      led  = leds[k];
      endc = end_of(led);
      acc  = acc_of(led);
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      for (int t = 1; t <= endc + 1; t++) begin
        LED = (t == led);
        @(negedge clk);
        p   = pos(t, endc);
        exp = {exp_ins(p), exp_num(p), t < endc, t == endc, acc && (t >= endc)};
        act = {insere, numero, ocupado, concluido, aceito};
        n_checks++;
        if (act !== exp) $display("FAIL led_case%0d t=%0d got %b want %b", k, t, act, exp);
        else n_pass++;
`ifdef REPETE_EN
        if (t == endc) begin
          n_checks++;
          if (tentativas !== ((endc > A + 1) ? 2'd2 : 2'd1))
            $display("FAIL tentativas case%0d got %0d want %0d", k, tentativas, (endc > A + 1) ? 2 : 1);
          else n_pass++;
        end
`endif
        tick();
      end
      LED = 1'b0;
    end
  endtask

  task automatic test_write_busy;
    int endc, p;
    logic [7:0] act, exp;
    endc = end_of(0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        write_slot(5, 7);
        grava = 1'b1; endereco = 3'd0; dado = 4'd3;
      end
      iniciar = 1'b1; tick(); iniciar = 1'b0; grava = 1'b0;
      for (int t = 1; t <= endc + 1; t++) begin
        grava = (k == 0 && t == 3); endereco = 3'd2; dado = 4'd8;
        @(negedge clk);
        p   = pos(t, endc);
        exp = {exp_ins(p), exp_num(p), t < endc, t == endc, 1'b0};
        act = {insere, numero, ocupado, concluido, aceito};
        n_checks++;
        if (act !== exp) $display("FAIL write_busy%0d t=%0d got %b want %b", k, t, act, exp);
        else n_pass++;
        tick();
      end
      grava = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    int endc, p;
    logic [7:0] act, exp;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    for (int t = 1; t <= 2 * P + 2; t++) begin
      @(negedge clk);
      if (t < 2 * P + 2) tick();
    end
    act = {insere, numero, ocupado};
    exp = {2'b00, 1'b0, model[2][3:0], 1'b1};
    n_checks++;
    if (act[5:0] !== exp[5:0]) $display("FAIL pre_reset_pausa got %b want %b", act[5:0], exp[5:0]);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    act = {insere, numero, ocupado, concluido, aceito};
    n_checks++;
    if (act !== 8'h00) $display("FAIL reset_async got %b want 00000000", act);
    else n_pass++;
    #1 reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) model[i] = 0;
    endc = end_of(0);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    for (int t = 1; t <= endc + 1; t++) begin
      @(negedge clk);
      p   = pos(t, endc);
      exp = {exp_ins(p), exp_num(p), t < endc, t == endc, 1'b0};
      act = {insere, numero, ocupado, concluido, aceito};
      n_checks++;
      if (act !== exp) $display("FAIL after_reset t=%0d got %b want %b", t, act, exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int endc, p, tt;
    logic [7:0] act, exp;
    endc = end_of(0);
    write_slot(1, 6);
    iniciar = 1'b1; tick();
    for (int t = 1; t <= 2 * (endc + 1); t++) begin
      if (t == 2 * (endc + 1)) iniciar = 1'b0;
      @(negedge clk);
      tt  = (t > endc + 1) ? t - (endc + 1) : t;
      p   = pos(tt, endc);
      exp = {exp_ins(p), exp_num(p), tt < endc, tt == endc, 1'b0};
      act = {insere, numero, ocupado, concluido, aceito};
      n_checks++;
      if (act !== exp) $display("FAIL back_to_back t=%0d got %b want %b", t, act, exp);
      else n_pass++;
      tick();
    end
    iniciar = 1'b0;
  endtask

  task automatic test_random;
    int endc, p, led;
    logic acc;
    logic [7:0] act, exp;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < 4; w++)
        write_slot(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      led  = int'($urandom_range(0, end_of(0) + 1));
      endc = end_of(led);
      acc  = acc_of(led);
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      for (int t = 1; t <= endc + 1; t++) begin
        LED      = (t == led);
        grava    = (t < endc) && ($urandom_range(0, 3) == 0);
        endereco = 3'($urandom_range(0, 7));
        dado     = 4'($urandom_range(0, 15));
        @(negedge clk);
        p   = pos(t, endc);
        exp = {exp_ins(p), exp_num(p), t < endc, t == endc, acc && (t >= endc)};
        act = {insere, numero, ocupado, concluido, aceito};
        n_checks++;
        if (act !== exp) $display("FAIL random%0d led=%0d t=%0d got %b want %b", k, led, t, act, exp);
        else n_pass++;
        tick();
      end
      LED = 1'b0; grava = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; grava = 1'b0; iniciar = 1'b0; LED = 1'b0;
    endereco = 3'd0; dado = 4'd0;
    for (int i = 0; i < N; i++) model[i] = 0;
    test_reset();
    test_led_handling();
    test_write_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
